// File: rtl/iq_integrate_dump.sv
// I/Q integrate-and-dump: sums 16-bit lanes, accumulates over a window,
// then scales by an arithmetic right shift and saturates to 16 bits.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   data_in_i/q, _valid     - NUMBER_OF_LINE packed signed 16-bit lanes
//   dump_length, shift      - window length (0 means 1) and output shift
//   data_out_i/q, _valid    - saturated integrals, one-cycle valid pulse
//   overflow                - sticky flag, set when a dump saturates
module iq_integrate_dump #(
   parameter int NUMBER_OF_LINE = 8,
   parameter int ACC_WIDTH      = 40
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [16*NUMBER_OF_LINE-1:0] data_in_i,
   input  logic [16*NUMBER_OF_LINE-1:0] data_in_q,
   input  logic                        data_in_valid,
   input  logic [15:0]                 dump_length,
   input  logic [4:0]                  shift,
   output logic [15:0]                 data_out_i,
   output logic [15:0]                 data_out_q,
   output logic                        data_out_valid,
   output logic                        overflow
);

   localparam int SUM_W = 19;

   typedef enum logic {
      IDLE,
      INTEG
   } state_t;

   // ---------------- stage 1: lane sums ----------------
   logic [SUM_W-1:0] sum_i_d, sum_q_d;
   logic [SUM_W-1:0] sum_i_q, sum_q_q;
   logic             s1_vld_q;
   logic [15:0]      s1_len_q;
   logic [4:0]       s1_sh_q;

   always_comb begin
      sum_i_d = '0;
      sum_q_d = '0;
      for (int k = 0; k < NUMBER_OF_LINE; k++) begin
         sum_i_d = sum_i_d
                 + {{(SUM_W-16){data_in_i[16*k+15]}}, data_in_i[16*k +: 16]};
         sum_q_d = sum_q_d
                 + {{(SUM_W-16){data_in_q[16*k+15]}}, data_in_q[16*k +: 16]};
      end
   end

   // Window controls travel with the beat so they are latched against
   // the same beat that opens the window.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_vld_q <= 1'b0;
         sum_i_q  <= '0;
         sum_q_q  <= '0;
         s1_len_q <= '0;
         s1_sh_q  <= '0;
      end else begin
         s1_vld_q <= data_in_valid;
         sum_i_q  <= sum_i_d;
         sum_q_q  <= sum_q_d;
         s1_len_q <= dump_length;
         s1_sh_q  <= shift;
      end
   end

   // ---------------- stage 2: accumulator FSM ----------------
   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_i_q, acc_i_d;
   logic [ACC_WIDTH-1:0]   acc_q_q, acc_q_d;
   logic [15:0]            cnt_q, cnt_d;
   logic [15:0]            len_q, len_d;
   logic [4:0]             sh_q, sh_d;
   logic                   dump_q, dump_d;
   logic [ACC_WIDTH-1:0]   ext_i, ext_q;
   logic [15:0]            len_in;

   assign ext_i  = {{(ACC_WIDTH-SUM_W){sum_i_q[SUM_W-1]}}, sum_i_q};
   assign ext_q  = {{(ACC_WIDTH-SUM_W){sum_q_q[SUM_W-1]}}, sum_q_q};
   assign len_in = (s1_len_q == 16'd0) ? 16'd1 : s1_len_q;

   always_comb begin
      state_d = state_q;
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      sh_d    = sh_q;
      dump_d  = 1'b0;
      if (s1_vld_q) begin
         unique case (state_q)
            IDLE: begin
               acc_i_d = ext_i;
               acc_q_d = ext_q;
               len_d   = len_in;
               sh_d    = s1_sh_q;
               cnt_d   = 16'd1;
               if (len_in == 16'd1) begin
                  dump_d = 1'b1;
               end else begin
                  state_d = INTEG;
               end
            end
            INTEG: begin
               acc_i_d = acc_i_q + ext_i;
               acc_q_d = acc_q_q + ext_q;
               cnt_d   = cnt_q + 16'd1;
               if (cnt_d == len_q) begin
                  dump_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         acc_i_q <= '0;
         acc_q_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         sh_q    <= '0;
         dump_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_i_q <= acc_i_d;
         acc_q_q <= acc_q_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         sh_q    <= sh_d;
         dump_q  <= dump_d;
      end
   end

   // ---------------- stage 3: scale and saturate ----------------
   // A following window may reload acc/shift on the same edge that this
   // stage captures them; the registered values are still the dumped ones.
   function automatic logic [16:0] sat16(input logic [ACC_WIDTH-1:0] v);
      logic [ACC_WIDTH-16:0] hi;
      hi = v[ACC_WIDTH-1:15];
      if ((&hi) || !(|hi)) begin
         sat16 = {1'b0, v[15:0]};
      end else if (v[ACC_WIDTH-1]) begin
         sat16 = {1'b1, 16'h8000};
      end else begin
         sat16 = {1'b1, 16'h7fff};
      end
   endfunction

   logic [ACC_WIDTH-1:0] shr_i, shr_q;
   logic [16:0]          sat_i, sat_q;
   logic [15:0]          out_i_q, out_q_q;
   logic                 out_vld_q, ovf_q;

   assign shr_i = $unsigned($signed(acc_i_q) >>> sh_q);
   assign shr_q = $unsigned($signed(acc_q_q) >>> sh_q);
   assign sat_i = sat16(shr_i);
   assign sat_q = sat16(shr_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         out_i_q   <= '0;
         out_q_q   <= '0;
         out_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         out_vld_q <= dump_q;
         if (dump_q) begin
            out_i_q <= sat_i[15:0];
            out_q_q <= sat_q[15:0];
            ovf_q   <= ovf_q | sat_i[16] | sat_q[16];
         end
      end
   end

   assign data_out_i     = out_i_q;
   assign data_out_q     = out_q_q;
   assign data_out_valid = out_vld_q;
   assign overflow       = ovf_q;

endmodule

// File: tb/tb_iq_integrate_dump.sv
// Bench for iq_integrate_dump: table of window scenarios with
// hand-computed integrals, plus directed reset and length-change sequences.
module tb_iq_integrate_dump;

   localparam int N = 8;

   logic            clock = 1'b0;
   logic            reset;
   logic [16*N-1:0] data_in_i, data_in_q;
   logic            data_in_valid;
   logic [15:0]     dump_length;
   logic [4:0]      shift;
   logic [15:0]     data_out_i, data_out_q;
   logic            data_out_valid, overflow;

   iq_integrate_dump #(.NUMBER_OF_LINE(N), .ACC_WIDTH(40)) dut (
      .clock(clock), .reset(reset),
      .data_in_i(data_in_i), .data_in_q(data_in_q),
      .data_in_valid(data_in_valid),
      .dump_length(dump_length), .shift(shift),
      .data_out_i(data_out_i), .data_out_q(data_out_q),
      .data_out_valid(data_out_valid), .overflow(overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      int c;
      int i;
      int q;
   } pulse_t;

   typedef struct {
      bit rst;
      int len;
      int sh;
      int iv;
      int qv;
      bit ramp;
      bit gap;
      int beats;
      int npulse;
      int ei;
      int eq;
      int eovf;
   } vec_t;

   int     cyc = 0;
   pulse_t pq[$];
   int     beat_cyc[$];
   int     n_pass = 0;
   int     n_tot = 0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock)
      if (data_out_valid)
         pq.push_back('{cyc, int'($signed(data_out_i)),
                        int'($signed(data_out_q))});

   task automatic chk(string nm, int act, int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic drive(bit v, int iv, int qv, bit ramp);
      data_in_valid = v;
      for (int k = 0; k < N; k++) begin
         data_in_i[16*k +: 16] = ramp ? 16'(k) : 16'(iv);
         data_in_q[16*k +: 16] = ramp ? 16'(-k) : 16'(qv);
      end
      if (v) beat_cyc.push_back(cyc);
      @(negedge clock);
   endtask

   task automatic flush();
      repeat (6) drive(1'b0, 0, 0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 0, 0, 1'b0);
      chk("rst out_i", int'(data_out_i), 0);
      chk("rst out_q", int'(data_out_q), 0);
      chk("rst valid", int'(data_out_valid), 0);
      chk("rst ovf", int'(overflow), 0);
      reset = 1'b0;
      pq.delete();
      beat_cyc.delete();
   endtask

   // Compare captured pulses against expected values and the beat index
   // that closes each window (pulse lands 3 cycles after that beat).
   task automatic check_list(string nm, int ei[$], int eq[$], int ix[$]);
      chk({nm, " npulse"}, pq.size(), ei.size());
      for (int p = 0; p < ei.size() && p < pq.size(); p++) begin
         chk({nm, " I"}, pq[p].i, ei[p]);
         chk({nm, " Q"}, pq[p].q, eq[p]);
         if (ix[p] < beat_cyc.size())
            chk({nm, " cycle"}, pq[p].c, beat_cyc[ix[p]] + 3);
         else
            chk({nm, " beat idx"}, ix[p], beat_cyc.size() - 1);
      end
      pq.delete();
      beat_cyc.delete();
   endtask

   initial begin
      vec_t vt[9];
      int   qi[$], qq[$], qx[$];
      int   L;

      vt[0] = '{1, 4, 0, 1, -1, 0, 0, 12, 3, 32, -32, 0};
      vt[1] = '{1, 2, 0, 100, 0, 0, 1, 6, 3, 1600, 0, 0};
      vt[2] = '{1, 16, 8, 32767, -32768, 0, 0, 16, 1, 16383, -16384, 0};
      vt[3] = '{1, 0, 0, 0, 0, 1, 0, 5, 5, 28, -28, 0};
      vt[4] = '{1, 1, 4, 3, -1, 0, 0, 3, 3, 1, -1, 0};
      vt[5] = '{1, 3, 2, -5, 7, 0, 0, 6, 2, -30, 42, 0};
      vt[6] = '{1, 2, 0, 20000, 0, 0, 0, 2, 1, 32767, 0, 1};
      vt[7] = '{1, 16, 0, 32767, -32768, 0, 0, 16, 1, 32767, -32768, 1};
      vt[8] = '{0, 4, 0, 1, -1, 0, 0, 4, 1, 32, -32, 1};

      reset         = 1'b1;
      data_in_valid = 1'b0;
      data_in_i     = '0;
      data_in_q     = '0;
      dump_length   = 16'd4;
      shift         = 5'd0;
      @(negedge clock);

      for (int v = 0; v < 9; v++) begin
         if (vt[v].rst) do_reset();
         dump_length = 16'(vt[v].len);
         shift       = 5'(vt[v].sh);
         for (int b = 0; b < vt[v].beats; b++) begin
            drive(1'b1, vt[v].iv, vt[v].qv, vt[v].ramp);
            if (vt[v].gap) drive(1'b0, 7777, -7777, 1'b0);
         end
         flush();
         L = (vt[v].len == 0) ? 1 : vt[v].len;
         qi.delete(); qq.delete(); qx.delete();
         for (int p = 0; p < vt[v].npulse; p++) begin
            qi.push_back(vt[v].ei);
            qq.push_back(vt[v].eq);
            qx.push_back((p + 1) * L - 1);
         end
         check_list($sformatf("vec%0d", v), qi, qq, qx);
         chk($sformatf("vec%0d ovf", v), int'(overflow), vt[v].eovf);
         chk($sformatf("vec%0d hold", v),
             int'($signed(data_out_i)), vt[v].ei);
      end

      // Length and shift change mid-window only affect the next window.
      do_reset();
      dump_length = 16'd4;
      shift       = 5'd0;
      repeat (2) drive(1'b1, 1, 0, 1'b0);
      dump_length = 16'd2;
      shift       = 5'd1;
      repeat (6) drive(1'b1, 1, 0, 1'b0);
      flush();
      check_list("lenchg", '{32, 8, 8}, '{0, 0, 0}, '{3, 5, 7});

      // Reset after 2 of 4 beats, then again with a dump already in the
      // pipeline; neither aborted window may produce a pulse.
      do_reset();
      dump_length = 16'd4;
      shift       = 5'd0;
      repeat (2) drive(1'b1, 1, 0, 1'b0);
      reset = 1'b1;
      drive(1'b0, 0, 0, 1'b0);
      reset = 1'b0;
      repeat (4) drive(1'b1, 1, 0, 1'b0);
      drive(1'b0, 0, 0, 1'b0);
      reset = 1'b1;
      drive(1'b0, 0, 0, 1'b0);
      reset = 1'b0;
      beat_cyc.delete();
      repeat (4) drive(1'b1, 2, 0, 1'b0);
      flush();
      check_list("rstmid", '{64}, '{0}, '{3});
      chk("rstmid ovf", int'(overflow), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
